// File: rtl/mem_access_ctrl_if.sv
// Core-side request/response bundle for the load/store controller.
// The controller takes the slave modport; the core side takes the master modport.
interface mem_access_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              req;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] source1;
  logic [ADDR_W-1:0] offset;
  logic [DATA_W-1:0] source2;
  logic              busy;
  logic              done;
  logic              LDR_select;
  logic [DATA_W-1:0] LDR_out;
  logic              ADR_select;
  logic [ADDR_W-1:0] ADR_out;
  logic              RAM_RW;

  modport master (
    output req, opcode, source1, offset, source2,
    input  busy, done, LDR_select, LDR_out, ADR_select, ADR_out, RAM_RW
  );

  modport slave (
    input  req, opcode, source1, offset, source2,
    output busy, done, LDR_select, LDR_out, ADR_select, ADR_out, RAM_RW
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multi-cycle LDR/STR controller: forms base+offset, runs WAIT_STATES+1 access
// cycles on the shared RAM databus, then pulses done for one cycle.
//
//  state  | meaning
//  IDLE   | no access in flight, all strobes low
//  ACCESS | address on RAM, core stalled; store data driven on databus
//  DONE   | one-cycle completion; may accept the next request directly
module mem_access_ctrl #(
  parameter int         DATA_W      = 32,
  parameter int         ADDR_W      = 16,
  parameter int         WAIT_STATES = 1,
  parameter logic [3:0] OPC_LDR     = 4'b1101,
  parameter logic [3:0] OPC_STR     = 4'b1110
) (
  input  logic              clock,
  input  logic              reset,
  mem_access_ctrl_if.slave  bus,
  inout  wire  [DATA_W-1:0] databus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              op_str;
  logic [DATA_W-1:0] wdata;
  logic              busy_q;
  logic              done_q;
  logic              ldr_sel_q;
  logic [DATA_W-1:0] ldr_out_q;
  logic              adr_sel_q;
  logic [ADDR_W-1:0] adr_out_q;
  logic              ram_rw_q;
  logic              is_mem_op;
  logic              accept;
  logic              unused_src1_hi;

  assign is_mem_op = (bus.opcode == OPC_LDR) || (bus.opcode == OPC_STR);
  assign accept    = (state != ACCESS) && bus.req && is_mem_op;

  // Upper base-register bits do not reach the RAM address.
  assign unused_src1_hi = ^bus.source1[DATA_W-1:ADDR_W];

  // ram_rw_q is high exactly in store ACCESS, and reset clears it asynchronously,
  // so the bus is released the moment reset asserts.
  assign databus = ram_rw_q ? wdata : {DATA_W{1'bz}};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      op_str    <= 1'b0;
      wdata     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ldr_sel_q <= 1'b0;
      ldr_out_q <= '0;
      adr_sel_q <= 1'b0;
      adr_out_q <= '0;
      ram_rw_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q    <= 1'b0;
          ldr_sel_q <= 1'b0;
          if (accept) begin
            state     <= ACCESS;
            op_str    <= (bus.opcode == OPC_STR);
            adr_out_q <= bus.source1[ADDR_W-1:0] + bus.offset;
            wdata     <= bus.source2;
            wait_cnt  <= WAIT_CNT;
            busy_q    <= 1'b1;
            adr_sel_q <= 1'b1;
            ram_rw_q  <= (bus.opcode == OPC_STR);
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            state     <= DONE;
            busy_q    <= 1'b0;
            adr_sel_q <= 1'b0;
            ram_rw_q  <= 1'b0;
            done_q    <= 1'b1;
            ldr_sel_q <= !op_str;
            if (!op_str) ldr_out_q <= databus;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.LDR_select = ldr_sel_q;
  assign bus.LDR_out    = ldr_out_q;
  assign bus.ADR_select = adr_sel_q;
  assign bus.ADR_out    = adr_out_q;
  assign bus.RAM_RW     = ram_rw_q;

endmodule
